conv_pe_row: RTL and testbench

CONV_PE_ROW -- requirements
Module: conv_pe_row

---
 rtl/conv_pe_row.sv | 134 +++++++++++++
 tb/tb_conv_pe_row.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pe_row.sv
// Row processing element: captures one packed row plus weights, then streams one
// K-tap signed dot product per accepted psum. Define CONV_PE_ROW_RELU_EN to clamp negative sums to 0.
module conv_pe_row #(
  parameter int DATA_WIDTH  = 8,
  parameter int INPUT_SIZE  = 28,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            mode,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [INPUT_SIZE*DATA_WIDTH-1:0]                data_in,
  input  logic [INPUT_SIZE*DATA_WIDTH-1:0]                weight_in,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic signed [2*DATA_WIDTH+$clog2(KERNEL_SIZE):0] psum,
  output logic                                            out_last,
  output logic                                            done
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2*DATA_WIDTH + $clog2(KERNEL_SIZE) + 1;
  localparam int IW = $clog2(INPUT_SIZE + 1);
  localparam int N0 = INPUT_SIZE - KERNEL_SIZE + 1;
  localparam int N1 = INPUT_SIZE / KERNEL_SIZE;
  localparam logic [IW-1:0] LAST0 = IW'(N0 - 1);
  localparam logic [IW-1:0] LAST1 = IW'(N1 - 1);
  localparam logic [IW-1:0] K_IW  = IW'(KERNEL_SIZE);
  localparam logic [IW-1:0] ONE   = IW'(1);

  typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  mode_q, mode_d;
  logic signed [DW-1:0]  data_q   [INPUT_SIZE];
  logic signed [DW-1:0]  weight_q [INPUT_SIZE];
  logic                  capture;
  logic [IW-1:0]         last_idx;
  logic [IW-1:0]         base;
  logic [IW-1:0]         wbase;
  logic signed [2*DW-1:0] prod [KERNEL_SIZE];
  logic signed [PW-1:0]  sum;

  assign capture  = (state_q == IDLE) && in_valid;
  assign last_idx = mode_q ? LAST1 : LAST0;
  // Segmented mode steps by K and uses the weights under the same window.
  assign base     = mode_q ? (idx_q * K_IW) : idx_q;
  assign wbase    = mode_q ? base : '0;

  for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_tap
    localparam logic [IW-1:0] TAP = IW'(gi);
    logic [IW-1:0] d_sel;
    logic [IW-1:0] w_sel;
    assign d_sel    = base + TAP;
    assign w_sel    = wbase + TAP;
    assign prod[gi] = data_q[d_sel] * weight_q[w_sel];
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      sum = sum + PW'(prod[k]);
    end
  end

  for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_store
    always_ff @(posedge clk) begin
      if (capture) begin
        data_q[gi]   <= data_in[gi*DW +: DW];
        weight_q[gi] <= weight_in[gi*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = mode;
          idx_d   = '0;
          state_d = COMP;
        end
      end
      COMP: begin
        if (out_ready) begin
          if (idx_q == last_idx) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == COMP);
    out_last  = (state_q == COMP) && (idx_q == last_idx);
    done      = (state_q == DONE);
    psum      = '0;
    if (state_q == COMP) begin
`ifdef CONV_PE_ROW_RELU_EN
      psum = sum[PW-1] ? '0 : sum;
`else
      psum = sum;
`endif
    end
  end

endmodule

// File: tb/tb_conv_pe_row.sv
// Randomized self-checking bench for conv_pe_row against an array-based window model.
module tb_conv_pe_row;

  localparam int DW = 8;
  localparam int IS = 28;
  localparam int K  = 3;
  localparam int PW = 2*DW + $clog2(K) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [IS*DW-1:0]     data_in;
  logic [IS*DW-1:0]     weight_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [PW-1:0] psum;
  logic                 out_last;
  logic                 done;

  int n_cmp = 0;
  int n_bad = 0;
  int d_row [IS];
  int w_row [IS];

  always #5 clk = ~clk;

  conv_pe_row #(.DATA_WIDTH(DW), .INPUT_SIZE(IS), .KERNEL_SIZE(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .weight_in (weight_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .psum      (psum),
    .out_last  (out_last),
    .done      (done)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int num_windows(input bit m);
    return m ? (IS / K) : (IS - K + 1);
  endfunction

  // Window w of the row: stride 1 with weights 0..K-1, or stride K with aligned weights.
  function automatic longint model_psum(input bit m, input int w);
    longint s = 0;
    int db = m ? w*K : w;
    int wb = m ? w*K : 0;
    for (int k = 0; k < K; k++) s += longint'(d_row[db+k]) * longint'(w_row[wb+k]);
`ifdef CONV_PE_ROW_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic drive_row(input bit m);
    logic [31:0] dv, wv;
    for (int i = 0; i < IS; i++) begin
      dv = d_row[i];
      wv = w_row[i];
      data_in[i*DW +: DW]   = dv[DW-1:0];
      weight_in[i*DW +: DW] = wv[DW-1:0];
    end
    mode = m;
  endtask

  task automatic scramble();
    for (int i = 0; i < IS*DW/32; i++) begin
      data_in[i*32 +: 32]   = $urandom();
      weight_in[i*32 +: 32] = $urandom();
    end
    mode = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_row();
    for (int i = 0; i < IS; i++) begin
      d_row[i] = int'($urandom_range(0, 255)) - 128;
      w_row[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // ready_kind: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  task automatic run_row(input bit m, input int ready_kind, input bit hold, input int abort_at);
    int  n   = num_windows(m);
    int  j   = 0;
    int  cyc = 0;
    bit  rdy;
    bit  fin = 1'b0;
    drive_row(m);
    in_valid = 1'b1;
    while (!in_ready && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("accept_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    cyc = 0;
    while (!fin && cyc < 4*n + 10) begin
      scramble();
      check_eq("in_ready_busy", longint'(in_ready), 0);
      if (j < n) begin
        check_eq("out_valid", longint'(out_valid), 1);
        check_eq($sformatf("psum_m%0d_w%0d", m, j), longint'(psum), model_psum(m, j));
        check_eq("out_last", longint'(out_last), longint'(j == n-1));
        check_eq("done_low", longint'(done), 0);
        if (abort_at >= 0 && j == abort_at) begin
          rst = 1'b0;
          #1;
          check_eq("rst_out_valid", longint'(out_valid), 0);
          check_eq("rst_psum", longint'(psum), 0);
          check_eq("rst_out_last", longint'(out_last), 0);
          check_eq("rst_done", longint'(done), 0);
          in_valid  = 1'b0;
          out_ready = 1'b1;
          @(posedge clk); #2;
          rst = 1'b1;
          @(posedge clk); #1;
          check_eq("post_rst_in_ready", longint'(in_ready), 1);
          check_eq("post_rst_out_valid", longint'(out_valid), 0);
          return;
        end
        case (ready_kind)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 3 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        out_ready = rdy;
        if (rdy) j++;
      end else begin
        check_eq("done_pulse", longint'(done), 1);
        check_eq("done_out_valid", longint'(out_valid), 0);
        check_eq("done_psum", longint'(psum), 0);
        check_eq("done_out_last", longint'(out_last), 0);
        fin = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!fin) check_eq("row_timeout", 0, 1);
    $display("row mode=%0d ready_kind=%0d hold=%0d windows=%0d compared=%0d mismatched=%0d",
             m, ready_kind, hold, n, n_cmp, n_bad);
  endtask

  task automatic ramp_row();
    for (int i = 0; i < IS; i++) begin
      d_row[i] = i + 1;
      w_row[i] = (i < K) ? 1 : 0;
    end
  endtask

  initial begin
    rst       = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    weight_in = '0;
    #12;
    check_eq("reset_out_valid", longint'(out_valid), 0);
    check_eq("reset_psum", longint'(psum), 0);
    check_eq("reset_out_last", longint'(out_last), 0);
    check_eq("reset_done", longint'(done), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("reset_in_ready", longint'(in_ready), 1);

    ramp_row();
    run_row(1'b0, 0, 1'b0, -1);

    for (int i = 0; i < IS; i++) begin
      d_row[i] = 2;
      w_row[i] = 3;
    end
    run_row(1'b1, 0, 1'b0, -1);

    ramp_row();
    run_row(1'b0, 1, 1'b0, -1);

    for (int i = 0; i < IS; i++) begin
      d_row[i] = -128;
      w_row[i] = 127;
    end
    run_row(1'b0, 0, 1'b0, -1);
    run_row(1'b1, 2, 1'b0, -1);

    ramp_row();
    run_row(1'b0, 0, 1'b0, 4);
    rand_row();
    run_row(1'b0, 0, 1'b0, -1);

    rand_row();
    run_row(1'b1, 0, 1'b1, -1);
    rand_row();
    run_row(1'b0, 0, 1'b1, -1);
    rand_row();
    run_row(1'b1, 2, 1'b0, -1);

    for (int r = 0; r < 12; r++) begin
      rand_row();
      run_row(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
